// File: rtl/ds_pkg.sv
// ds_pkg: shared types and helpers for the ds stream blocks.
//   t_arb        arbitration policy (round-robin / fixed lowest-index)
//   t_fc         downstream flow-control flavour
//   t_arb_state  ds_arb FSM state encoding
//   f_idx_w(n)   width of a requester index, never less than 1 bit
package ds_pkg;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } t_arb;

    typedef enum logic [1:0] {
        FC_BI,
        FC_UNI,
        FC_NO
    } t_fc;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } t_arb_state;

    function automatic int f_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ds_arb_pick.sv
// ds_arb_pick: combinational winner picker.
//   req  in   N_REQ  request vector
//   ptr  in   IDX_W  round-robin pointer (last served index); unused for ARB_FIXED
//   idx  out  IDX_W  winning index (0 when nothing requests)
//   any  out  1      at least one request is asserted
// ARB_RR picks the first asserted index scanning ptr+1, ptr+2, ... modulo N_REQ.
// ARB_FIXED picks the lowest asserted index.
module ds_arb_pick
    import ds_pkg::*;
#(
    parameter int   N_REQ = 4,
    parameter t_arb ARB   = ARB_RR,
    parameter int   IDX_W = f_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // lo_*: lowest asserted index overall.
    // hi_*: lowest asserted index strictly above ptr.
    // The round-robin wrap-around scan is "hi if any, else lo".
    logic             lo_any;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_any;
    logic [IDX_W-1:0] hi_idx;

    always_comb begin
        lo_any = 1'b0;
        lo_idx = '0;
        hi_any = 1'b0;
        hi_idx = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) > ptr) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        any = lo_any;
        idx = lo_idx;
        if (ARB == ARB_RR && hi_any) begin
            idx = hi_idx;
        end
    end

endmodule

// File: rtl/ds_arb.sv
// ds_arb: N-to-1 stream arbiter with packet lock and a one-entry output register.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_vld/o_rdy      per-requester handshake, i_data packed k*DATA_W +: DATA_W
//   i_last           per-requester end-of-packet
//   o_vld/i_rdy      downstream handshake (i_rdy only honoured for FC_BI)
//   o_data, o_last   output payload / end-of-packet
//   o_idx            requester index the output beat came from
//   o_dbg_state      FSM state (0 = IDLE, 1 = LOCK)
// Handshake: a beat moves across an interface on a clock edge where both
// valid and ready are high. Valid never depends on ready; once the output
// register holds a beat (o_vld=1) it stays unchanged until downstream ready
// takes it. Upstream ready is combinational from the request vector (zero-cycle
// arbitration) and from the output slot being free.
module ds_arb
    import ds_pkg::*;
#(
    parameter int   N_REQ    = 4,
    parameter int   DATA_W   = 32,
    parameter t_arb ARB      = ARB_RR,
    parameter t_fc  FC       = FC_BI,
    parameter int   LOCK_PKT = 1,
    parameter int   IDX_W    = f_idx_w(N_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_vld,
    output logic [N_REQ-1:0]          o_rdy,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    input  logic [N_REQ-1:0]          i_last,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_last,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_dbg_state
);

    t_arb_state       state_q;
    t_arb_state       state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] ptr_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic [DATA_W-1:0] win_data;
    logic             win_last;
    logic             rdy_eff;
    logic             slot_free;
    logic             accept;

    ds_arb_pick #(
        .N_REQ (N_REQ),
        .ARB   (ARB),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (i_vld),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign rdy_eff     = (FC == FC_BI) ? i_rdy : 1'b1;
    // The register can take a new beat when empty or when it is being drained.
    assign slot_free   = !o_vld || rdy_eff;
    assign o_dbg_state = state_q;

    // Candidate: the fresh pick in IDLE, the locked grant in LOCK. A locked
    // requester that drops valid simply stalls the arbiter.
    always_comb begin
        win_idx = pick_idx;
        win_vld = pick_any;
        if (state_q == ST_LOCK) begin
            win_idx = grant_q;
            win_vld = i_vld[grant_q];
        end
    end

    // Payload mux and per-requester ready. Ready is forced low while reset is
    // asserted so nothing is handed over during reset.
    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        o_rdy    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_data = i_data[k*DATA_W +: DATA_W];
                win_last = i_last[k];
                o_rdy[k] = i_rst_n && slot_free && win_vld;
            end
        end
    end

    assign accept = |(i_vld & o_rdy);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (LOCK_PKT != 0 && accept && !win_last) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && win_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant and round-robin pointer. ptr starts at N_REQ-1 so requester 0 is
    // scanned first after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_q <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
        end else begin
            if (accept && state_q == ST_IDLE) begin
                grant_q <= win_idx;
            end
            if (ARB == ARB_RR && accept && (win_last || LOCK_PKT == 0)) begin
                ptr_q <= win_idx;
            end
        end
    end

    // Output register: loads on acceptance (also when draining the previous
    // beat in the same cycle), empties when drained with nothing new.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_last <= 1'b0;
            o_idx  <= '0;
        end else if (accept) begin
            o_vld  <= 1'b1;
            o_data <= win_data;
            o_last <= win_last;
            o_idx  <= win_idx;
        end else if (slot_free) begin
            o_vld  <= 1'b0;
        end
    end

endmodule

// File: doc/ds_arb.md
Name: ds_arb

Overview:
- N-to-1 stream arbiter. Shares one downstream ds stream (the serial-interconnect output or a FIFO write port) between N_REQ upstream requesters.
- Selects a winner by round-robin or fixed priority and locks the grant for a whole packet, delimited by last.
- Drives a one-entry registered output stage carrying the winning requester's index.
- Basic building block of ICON_ARCH_SERIAL interconnects.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- DATA_W, 32, payload width in bits.
- ARB, ARB_RR, arbitration policy of type t_arb (ARB_RR round-robin, ARB_FIXED lowest index wins).
- FC, FC_BI, downstream flow control of type t_fc. FC_UNI and FC_NO treat downstream ready as constant 1.
- LOCK_PKT, 1, 1 = hold grant until the last beat is accepted; 0 = re-arbitrate every beat.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_vld  in  N_REQ  per-requester valid.
- o_rdy  out  N_REQ  per-requester ready.
- i_data  in  N_REQ*DATA_W  packed payloads, requester k at bits [k*DATA_W +: DATA_W].
- i_last  in  N_REQ  per-requester end-of-packet.
- o_vld  out  1  output valid.
- i_rdy  in  1  downstream ready; ignored unless FC==FC_BI.
- o_data  out  DATA_W  output payload.
- o_last  out  1  output end-of-packet.
- o_idx  out  IDX_W  source index of the output beat; IDX_W = max(1, $clog2(N_REQ)).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - o_vld=0, o_data=0, o_last=0, o_idx=0, o_rdy=0.
  - state=IDLE, grant=0.
  - RR pointer ptr=N_REQ-1, so requester 0 has top priority first.
- Reset mid-packet: the in-flight output beat is dropped and the lock is released. No recovery of the partial packet.
- Definitions:
  - rdy_eff = (FC==FC_BI) ? i_rdy : 1.
  - slot_free = !o_vld | rdy_eff.
- State machine, 2 states:
  - IDLE: winner is picked combinationally among asserted i_vld.
    - ARB_RR: first asserted index scanning ptr+1, ptr+2, … modulo N_REQ.
    - ARB_FIXED: lowest asserted index.
    - Zero-cycle arbitration: the winner's first beat can be accepted in the same cycle it is picked.
  - LOCK: only the registered grant is served. Other requesters see o_rdy=0 regardless of i_vld.
- Acceptance:
  - o_rdy[k] = slot_free & (k == current winner/grant) & candidate-valid.
  - In IDLE with no i_vld, all o_rdy=0.
  - A beat is accepted when i_vld[k] & o_rdy[k].
  - On acceptance: o_vld<=1, o_data<=i_data[k], o_last<=i_last[k], o_idx<=k.
  - If slot_free and nothing is accepted, o_vld<=0.
  - Latency: acceptance to o_vld is 1 cycle. Full throughput of 1 beat/cycle when rdy_eff=1.
- Transitions:
  - IDLE -> LOCK: beat accepted with i_last=0 and LOCK_PKT=1; grant<=k.
  - LOCK -> IDLE: the grant's beat with i_last=1 is accepted.
  - Single-beat packet: stays in IDLE.
  - LOCK_PKT=0: never enters LOCK.
- ptr update (ARB_RR only): ptr<=k whenever a beat with i_last=1 is accepted (LOCK_PKT=1), or on every accepted beat (LOCK_PKT=0).
- Requester deasserts i_vld mid-packet in LOCK: the arbiter keeps the lock and waits indefinitely. No timeout, no preemption.
- Output held stable while o_vld=1 and rdy_eff=0 (FC_BI backpressure). No beat is overwritten or lost.
- N_REQ=1: degenerates to a registered pass-through; o_idx is constant 0.
- Simultaneous downstream pop and new acceptance in the same cycle: the register is loaded with the new beat and o_vld stays 1.

Decomposition:
- ds_pkg additions:
  - typedef enum t_arb {ARB_RR, ARB_FIXED}.
  - Function f_idx_w(n) returning max(1, $clog2(n)).
- Sub-module ds_arb_pick: combinational one-hot and index picker.
  - Inputs: request vector, ptr, ARB.
  - Outputs: winner index and any-valid flag.
  - Reusable by parallel interconnect arbiters.
- ds_arb holds the FSM, ptr, grant and output register.

Test Plan:
1. Reset release, all i_vld=0 for 10 cycles -> o_vld=0, o_rdy=0000, o_data=0.
2. ARB_RR, N_REQ=4, all four requesters send 1-beat packets (last=1) continuously, i_rdy=1 -> o_idx sequence 0,1,2,3,0,1, one beat per cycle, first o_vld one cycle after the first accept.
3. LOCK_PKT=1: req1 sends a 3-beat packet (data 0x11,0x12,0x13) while req2 holds i_vld -> output 0x11,0x12,0x13 all with o_idx=1 and contiguous, req2's beat follows; o_rdy[2]=0 throughout the lock.
4. FC_BI backpressure: i_rdy=0 for 5 cycles with a beat held -> o_data, o_idx, o_last stable and all o_rdy=0; on i_rdy=1, accept resumes with no duplicate or lost beat.
5. ARB_FIXED with req0 and req3 permanently valid, 1-beat packets -> o_idx always 0 and req3 starves. Under ARB_RR the same stimulus alternates 0,3,0,3.
6. Assert i_rst_n=0 mid-packet (after beat 2 of 4) -> o_vld=0 immediately (async). After release, state is IDLE and a new requester wins per ptr=N_REQ-1 priority.
